// File: rtl/axis_word_serializer_if.sv
// Stream bundle for axis_word_serializer: word-wide input side, beat-wide output side.
// The slave modport is the serialiser's view; master is the view of whatever drives it.
interface axis_word_serializer_if #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 8,
  parameter int DEPTH = 4
);
  localparam int RATIO = IN_W / OUT_W;
  localparam int LW    = $clog2(RATIO + 1);
  localparam int CW    = $clog2(DEPTH + 1);

  logic [IN_W-1:0]  s_data;
  logic [LW-1:0]    s_len;
  logic             s_last;
  logic             s_valid;
  logic             s_ready;
  logic [OUT_W-1:0] m_data;
  logic             m_valid;
  logic             m_last;
  logic             m_ready;
  logic [CW-1:0]    fifo_count;

  modport slave (
    input  s_data, s_len, s_last, s_valid, m_ready,
    output s_ready, m_data, m_valid, m_last, fifo_count
  );

  modport master (
    output s_data, s_len, s_last, s_valid, m_ready,
    input  s_ready, m_data, m_valid, m_last, fifo_count
  );
endinterface

// File: rtl/axis_word_serializer.sv
// Buffers IN_W-bit words in a small FIFO and streams each one out as OUT_W-bit beats,
// least-significant beat first, honouring backpressure on both sides.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | nothing in flight; pops the FIFO head as soon as one exists
//   LOAD    | head word sits in the shift register, first beat next cycle
//   SEND    | m_valid=1, current beat on m_data, advances on m_ready
module axis_word_serializer #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  axis_word_serializer_if.slave  bus
);
  localparam int RATIO = IN_W / OUT_W;
  localparam int LW    = $clog2(RATIO + 1);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = $clog2(DEPTH);
  localparam logic [LW-1:0] RATIO_L = LW'(RATIO);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND} state_t;

  state_t          state_q, state_d;
  logic [IN_W-1:0] shift_q, shift_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   idx_q, idx_d;
  logic            last_q, last_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [IN_W-1:0] mem_data_q [DEPTH];
  logic [LW-1:0]   mem_len_q  [DEPTH];
  logic            mem_last_q [DEPTH];

  logic            s_ready_int;
  logic            push;
  logic            pop;
  logic            fifo_empty;
  logic            final_beat;
  logic [LW-1:0]   s_len_clamped;

  // Ready comes only from the registered count, so a full FIFO refuses even while popping.
  assign s_ready_int   = (count_q != DEPTH_C);
  assign push          = bus.s_valid && s_ready_int;
  assign fifo_empty    = (count_q == '0);
  assign final_beat    = (idx_q == len_q - LW'(1));
  assign s_len_clamped = ((bus.s_len == '0) || (bus.s_len > RATIO_L)) ? RATIO_L : bus.s_len;

  assign bus.s_ready    = s_ready_int;
  assign bus.m_valid    = (state_q == ST_SEND);
  assign bus.m_data     = shift_q[OUT_W-1:0];
  assign bus.m_last     = (state_q == ST_SEND) && last_q && final_beat;
  assign bus.fifo_count = count_q;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    len_d   = len_q;
    idx_d   = idx_q;
    last_d  = last_q;
    pop     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (bus.m_ready) begin
          if (!final_beat) begin
            shift_d = shift_q >> OUT_W;
            idx_d   = idx_q + LW'(1);
          end else if (!fifo_empty) begin
            pop     = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Back-to-back words reload straight from the head so no bubble appears between them.
    if (pop) begin
      shift_d = mem_data_q[rd_ptr_q];
      len_d   = mem_len_q[rd_ptr_q];
      last_d  = mem_last_q[rd_ptr_q];
      idx_d   = '0;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= bus.s_data;
      mem_len_q[wr_ptr_q]  <= s_len_clamped;
      mem_last_q[wr_ptr_q] <= bus.s_last;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      last_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: tb/tb_axis_word_serializer.sv
// Bench for axis_word_serializer: directed scenarios plus a random run, with a byte-queue
// model of the output stream compared against the DUT on every falling edge.
module tb_axis_word_serializer;
  localparam int IN_W  = 64;
  localparam int OUT_W = 8;
  localparam int DEPTH = 4;
  localparam int RATIO = IN_W / OUT_W;
  localparam int LW    = $clog2(RATIO + 1);

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  axis_word_serializer_if #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) bus ();

  axis_word_serializer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  beat_t      exp_q[$];
  int         n_checks  = 0;
  int         n_errors  = 0;
  int         hs_count  = 0;
  int         cyc_cnt   = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;
  logic       prev_last  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp_len(input logic [LW-1:0] l);
    if (l == '0 || int'(l) > RATIO) return RATIO;
    return int'(l);
  endfunction

  // Model: every accepted word becomes clamp_len bytes, in order, last flag on the final
  // byte of an s_last word; the DUT must present exactly the head of this queue.
  always @(negedge clk) begin
    cyc_cnt++;
    if (!reset_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", bus.m_valid, 1'b1);
        chk("stall_data", bus.m_data, prev_data);
        chk("stall_last", bus.m_last, prev_last);
      end
      if (bus.m_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_beat", bus.m_valid, 1'b0);
        end else begin
          chk("beat_data", bus.m_data, exp_q[0].data);
          chk("beat_last", bus.m_last, exp_q[0].last);
          if (bus.m_ready) begin
            void'(exp_q.pop_front());
            hs_count++;
          end
        end
      end else begin
        chk("last_without_valid", bus.m_last, 1'b0);
      end
      chk("s_ready_rule", bus.s_ready, bus.fifo_count != DEPTH);
      chk("count_bound", bus.fifo_count <= DEPTH, 1'b1);
      if (bus.s_valid && bus.s_ready) begin
        int n;
        beat_t b;
        n = clamp_len(bus.s_len);
        for (int i = 0; i < n; i++) begin
          b.data = bus.s_data[i*8 +: 8];
          b.last = bus.s_last && (i == n - 1);
          exp_q.push_back(b);
        end
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      prev_last  = bus.m_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [63:0] d, input logic [LW-1:0] len, input logic last);
    logic rdy;
    logic done;
    done = 1'b0;
    bus.s_data  = d;
    bus.s_len   = len;
    bus.s_last  = last;
    bus.s_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      rdy = bus.s_ready;
      tick();
      if (rdy) done = 1'b1;
    end
    bus.s_valid = 1'b0;
    chk("push_accepted", done, 1'b1);
  endtask

  task automatic wait_beat(input logic [7:0] d);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (bus.m_valid && bus.m_data == d) found = 1'b1;
      else tick();
    end
    chk("wait_beat", found, 1'b1);
  endtask

  task automatic wait_drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (exp_q.size() == 0 && !bus.m_valid && bus.fifo_count == 0) done = 1'b1;
      else tick();
    end
    chk("drain", done, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w;
    logic        acc;
    int          c0;
    int          hs0;
    logic        got;

    bus.s_data = '0; bus.s_len = '0; bus.s_last = 1'b0; bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_m_valid", bus.m_valid, 1'b0);
    chk("rst_m_last", bus.m_last, 1'b0);
    chk("rst_m_data", bus.m_data, 8'h00);
    chk("rst_count", bus.fifo_count, 0);
    chk("rst_s_ready", bus.s_ready, 1'b1);
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // 1: single full word, latency 2 from push, then eight contiguous beats
    bus.m_ready = 1'b1;
    push_word(64'h0807_0605_0403_0201, 4'd0, 1'b1);
    chk("t1_lat0", bus.m_valid, 1'b0);
    tick();
    chk("t1_lat1", bus.m_valid, 1'b0);
    tick();
    for (int i = 1; i <= 8; i++) begin
      chk("t1_valid", bus.m_valid, 1'b1);
      chk("t1_data", bus.m_data, 8'(i));
      chk("t1_last", bus.m_last, i == 8);
      tick();
    end
    chk("t1_idle", bus.m_valid, 1'b0);
    chk("t1_count", bus.fifo_count, 0);

    // 2: stall on beat 03 for five cycles
    push_word(64'h0807_0605_0403_0201, 4'd0, 1'b1);
    wait_beat(8'h03);
    bus.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_hold_valid", bus.m_valid, 1'b1);
      chk("t2_hold_data", bus.m_data, 8'h03);
    end
    bus.m_ready = 1'b1;
    tick();
    for (int i = 4; i <= 8; i++) begin
      chk("t2_data", bus.m_data, 8'(i));
      chk("t2_last", bus.m_last, i == 8);
      tick();
    end
    chk("t2_idle", bus.m_valid, 1'b0);

    // 3: fill while stalled (one word in the serialiser plus DEPTH stored), then drain
    bus.m_ready = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      for (int b = 0; b < 8; b++) w[b*8 +: 8] = 8'(n * 16 + b);
      push_word(w, 4'd8, n == 5);
    end
    chk("t3_full_count", bus.fifo_count, DEPTH);
    chk("t3_full_ready", bus.s_ready, 1'b0);
    for (int b = 0; b < 8; b++) w[b*8 +: 8] = 8'(6 * 16 + b);
    bus.s_data = w; bus.s_len = 4'd8; bus.s_last = 1'b1; bus.s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_held_count", bus.fifo_count, DEPTH);
    end
    bus.m_ready = 1'b1;
    c0  = cyc_cnt;
    hs0 = hs_count;
    push_word(w, 4'd8, 1'b1);
    for (int i = 0; i < 200 && hs_count < hs0 + 48; i++) tick();
    chk("t3_beats", hs_count - hs0, 48);
    chk("t3_no_bubble", cyc_cnt - c0, 48);
    wait_drain();

    // 4: packet spanning a 3-beat word and a 2-beat word
    push_word(64'hAAAA_AAAA_AA03_0201, 4'd3, 1'b0);
    push_word(64'hBBBB_BBBB_BBBB_0504, 4'd2, 1'b1);
    wait_beat(8'h01);
    for (int i = 1; i <= 5; i++) begin
      chk("t4_valid", bus.m_valid, 1'b1);
      chk("t4_data", bus.m_data, 8'(i));
      chk("t4_last", bus.m_last, i == 5);
      tick();
    end
    chk("t4_idle", bus.m_valid, 1'b0);

    // 5: reset in the middle of a two-word load
    push_word(64'h0807_0605_0403_0201, 4'd0, 1'b0);
    push_word(64'h1817_1615_1413_1211, 4'd0, 1'b1);
    wait_beat(8'h03);
    reset_n = 1'b0;
    #1;
    chk("t5_valid", bus.m_valid, 1'b0);
    chk("t5_data", bus.m_data, 8'h00);
    chk("t5_count", bus.fifo_count, 0);
    chk("t5_last", bus.m_last, 1'b0);
    repeat (3) tick();
    reset_n = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.m_valid) got = 1'b1;
    end
    chk("t5_no_resume", got, 1'b0);
    chk("t5_count_after", bus.fifo_count, 0);

    // 6: random traffic, source holds each word until accepted
    bus.s_valid = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      acc = bus.s_valid && bus.s_ready;
      if (acc || !bus.s_valid) begin
        bus.s_valid = ($urandom_range(0, 1) == 1);
        bus.s_data  = {$urandom, $urandom};
        bus.s_len   = LW'($urandom_range(0, 15));
        bus.s_last  = ($urandom_range(0, 2) == 0);
      end
      bus.m_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
